// File: rtl/cpu_pkg.sv
// cpu_pkg: controller state encoding and opcode constants shared with the datapath
package cpu_pkg;
  typedef enum logic [3:0] {
    S_INIT,
    S_HALT,
    S_FETCH,
    S_DECODE,
    S_EX_LDA,
    S_EX_STA,
    S_EX_JMP,
    S_EX_ADD,
    S_ERROR
  } state_t;
  localparam logic [1:0] OP_LDA = 2'b00;
  localparam logic [1:0] OP_STA = 2'b01;
  localparam logic [1:0] OP_JMP = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;
endpackage

// File: rtl/cpu_controller_if.sv
// cpu_controller_if: run/op_code/mem_ready in, datapath selects/strobes, memory requests and status out
interface cpu_controller_if;
  logic run;
  logic [1:0] op_code;
  logic mem_ready;
  logic ir_on_adr;
  logic pc_on_adr;
  logic ld_ir;
  logic ld_ac;
  logic ld_pc;
  logic inc_pc;
  logic clr_pc;
  logic pass_add;
  logic mem_rd;
  logic mem_wr;
  logic busy;
  logic instr_done;
  logic err;
  modport slave (
    input run, op_code, mem_ready,
    output ir_on_adr, pc_on_adr, ld_ir, ld_ac, ld_pc, inc_pc, clr_pc, pass_add,
    output mem_rd, mem_wr, busy, instr_done, err
  );
  modport master (
    output run, op_code, mem_ready,
    input ir_on_adr, pc_on_adr, ld_ir, ld_ac, ld_pc, inc_pc, clr_pc, pass_add,
    input mem_rd, mem_wr, busy, instr_done, err
  );
endinterface

// File: rtl/cpu_controller.sv
// cpu_controller: fetch/decode/execute FSM with memory wait timeout; ports clk, rst (async high), bus (cpu_controller_if.slave)
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input logic clk,
  input logic rst,
  cpu_controller_if.slave bus
);
  state_t state, state_n;
  logic [7:0] wait_cnt;
  logic waiting, timeout;
  state_t run_next;
  assign waiting = state inside {S_FETCH, S_EX_LDA, S_EX_STA, S_EX_ADD};
  assign timeout = !bus.mem_ready && wait_cnt == 8'(MAX_WAIT - 1);
  assign run_next = bus.run ? S_FETCH : S_HALT;
  assign bus.busy = !(state inside {S_HALT, S_ERROR});
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_INIT;
      wait_cnt <= '0;
    end else begin
      state <= state_n;
      wait_cnt <= state_n != state ? 8'd0 : wait_cnt + 8'(waiting && !bus.mem_ready);
    end
  always_comb begin
    state_n = state;
    bus.ir_on_adr = 1'b0;
    bus.pc_on_adr = 1'b0;
    bus.ld_ir = 1'b0;
    bus.ld_ac = 1'b0;
    bus.ld_pc = 1'b0;
    bus.inc_pc = 1'b0;
    bus.clr_pc = 1'b0;
    bus.pass_add = 1'b0;
    bus.mem_rd = 1'b0;
    bus.mem_wr = 1'b0;
    bus.instr_done = 1'b0;
    bus.err = 1'b0;
    case (state)
      S_INIT: begin
        bus.clr_pc = 1'b1;
        state_n = run_next;
      end
      S_HALT: state_n = run_next;
      S_FETCH: begin
        bus.pc_on_adr = 1'b1;
        bus.mem_rd = 1'b1;
        bus.ld_ir = bus.mem_ready;
        bus.inc_pc = bus.mem_ready;
        state_n = bus.mem_ready ? S_DECODE : timeout ? S_ERROR : S_FETCH;
      end
      S_DECODE:
        state_n = bus.op_code == OP_LDA ? S_EX_LDA :
                  bus.op_code == OP_STA ? S_EX_STA :
                  bus.op_code == OP_JMP ? S_EX_JMP : S_EX_ADD;
      S_EX_LDA, S_EX_ADD: begin
        bus.ir_on_adr = 1'b1;
        bus.mem_rd = 1'b1;
        bus.pass_add = state == S_EX_ADD;
        bus.ld_ac = bus.mem_ready;
        bus.instr_done = bus.mem_ready;
        state_n = bus.mem_ready ? run_next : timeout ? S_ERROR : state;
      end
      S_EX_STA: begin
        bus.ir_on_adr = 1'b1;
        bus.mem_wr = 1'b1;
        bus.instr_done = bus.mem_ready;
        state_n = bus.mem_ready ? run_next : timeout ? S_ERROR : state;
      end
      S_EX_JMP: begin
        bus.ld_pc = 1'b1;
        bus.instr_done = 1'b1;
        state_n = run_next;
      end
      S_ERROR: bus.err = 1'b1;
      default: state_n = S_INIT;
    endcase
  end
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: vector table, async reset sequence and randomized run against a phase-level model
module tb_cpu_controller;
  localparam int MW = 4;
  localparam logic [12:0] IR = 13'h1000, PC = 13'h0800, LDIR = 13'h0400, LDAC = 13'h0200;
  localparam logic [12:0] LDPC = 13'h0100, INC = 13'h0080, CLR = 13'h0040, PASS = 13'h0020;
  localparam logic [12:0] RD = 13'h0010, WR = 13'h0008, BSY = 13'h0004, DONE = 13'h0002, E_ERR = 13'h0001;
  localparam logic [12:0] F_W = PC | RD | BSY;
  localparam logic [12:0] F_RDY = F_W | LDIR | INC;
  localparam int P_INIT = 0, P_HALT = 1, P_FETCH = 2, P_DEC = 3, P_EXEC = 4, P_ERR = 5;
  typedef struct {
    logic r;
    logic rn;
    logic [1:0] o;
    logic rd;
    logic [12:0] e;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [12:0] outs;
  int checks = 0;
  int passes = 0;
  int m_phase = P_INIT;
  int m_waits = 0;
  logic [1:0] m_op = 2'd0;
  vec_t tbl[$];
  cpu_controller_if bus ();
  cpu_controller #(.MAX_WAIT(MW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  assign outs = {bus.ir_on_adr, bus.pc_on_adr, bus.ld_ir, bus.ld_ac, bus.ld_pc, bus.inc_pc, bus.clr_pc,
                 bus.pass_add, bus.mem_rd, bus.mem_wr, bus.busy, bus.instr_done, bus.err};
  task automatic check(input string nm, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %b expected %b", nm, got, exp);
  endtask
  task automatic add(input logic r, input logic rn, input logic [1:0] o, input logic rd, input logic [12:0] e);
    vec_t v;
    v.r = r;
    v.rn = rn;
    v.o = o;
    v.rd = rd;
    v.e = e;
    tbl.push_back(v);
  endtask
  task automatic drive(input logic r, input logic rn, input logic [1:0] o, input logic rd);
    rst = r;
    bus.run = rn;
    bus.op_code = o;
    bus.mem_ready = rd;
  endtask
  task automatic model(input logic r, input logic rn, input logic [1:0] o, input logic rd, output logic [12:0] e);
    int np;
    int after;
    np = m_phase;
    e = 13'h0;
    after = rn ? P_FETCH : P_HALT;
    case (m_phase)
      P_INIT: begin
        e = CLR | BSY;
        np = after;
      end
      P_HALT: np = after;
      P_FETCH: begin
        e = rd ? F_RDY : F_W;
        if (rd) np = P_DEC;
        else if (m_waits + 1 == MW) np = P_ERR;
      end
      P_DEC: begin
        e = BSY;
        m_op = o;
        np = P_EXEC;
      end
      P_EXEC:
        if (m_op == 2'd2) begin
          e = LDPC | BSY | DONE;
          np = after;
        end else begin
          e = IR | BSY | (m_op == 2'd1 ? WR : RD) | (m_op == 2'd3 ? PASS : 13'h0);
          if (rd) begin
            e = e | DONE | (m_op == 2'd1 ? 13'h0 : LDAC);
            np = after;
          end else if (m_waits + 1 == MW) np = P_ERR;
        end
      default: e = E_ERR;
    endcase
    m_waits = np != m_phase ? 0 : m_waits + (rd ? 0 : 1);
    if (r) begin
      np = P_INIT;
      m_waits = 0;
    end
    m_phase = np;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [12:0] e;
    int err_cycles;
    drive(1'b1, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b1, 2'd0, 1'b1, CLR | BSY);
    add(1'b0, 1'b1, 2'd0, 1'b1, CLR | BSY);
    add(1'b0, 1'b1, 2'd0, 1'b1, F_RDY);
    add(1'b0, 1'b1, 2'd0, 1'b1, BSY);
    add(1'b0, 1'b1, 2'd0, 1'b1, IR | RD | LDAC | BSY | DONE);
    add(1'b0, 1'b1, 2'd2, 1'b1, F_RDY);
    add(1'b0, 1'b1, 2'd2, 1'b1, BSY);
    add(1'b0, 1'b1, 2'd2, 1'b1, LDPC | BSY | DONE);
    add(1'b0, 1'b1, 2'd1, 1'b1, F_RDY);
    add(1'b0, 1'b1, 2'd1, 1'b1, BSY);
    for (int k = 0; k < 3; k++) add(1'b0, 1'b1, 2'd1, 1'b0, IR | WR | BSY);
    add(1'b0, 1'b0, 2'd1, 1'b1, IR | WR | BSY | DONE);
    add(1'b0, 1'b0, 2'd0, 1'b0, 13'h0);
    add(1'b0, 1'b1, 2'd0, 1'b0, 13'h0);
    for (int k = 0; k < 4; k++) add(1'b0, 1'b1, 2'd0, 1'b0, F_W);
    add(1'b0, 1'b1, 2'd0, 1'b0, E_ERR);
    add(1'b0, 1'b1, 2'd0, 1'b1, E_ERR);
    add(1'b1, 1'b1, 2'd0, 1'b0, CLR | BSY);
    add(1'b0, 1'b1, 2'd0, 1'b0, CLR | BSY);
    for (int k = 0; k < 3; k++) add(1'b0, 1'b1, 2'd0, 1'b0, F_W);
    add(1'b0, 1'b1, 2'd0, 1'b1, F_RDY);
    add(1'b0, 1'b1, 2'd3, 1'b1, BSY);
    add(1'b0, 1'b0, 2'd3, 1'b0, IR | RD | PASS | BSY);
    add(1'b0, 1'b0, 2'd3, 1'b1, IR | RD | PASS | LDAC | BSY | DONE);
    add(1'b0, 1'b0, 2'd0, 1'b1, 13'h0);
    add(1'b0, 1'b1, 2'd0, 1'b1, 13'h0);
    add(1'b0, 1'b1, 2'd1, 1'b1, F_RDY);
    add(1'b0, 1'b1, 2'd1, 1'b1, BSY);
    add(1'b0, 1'b1, 2'd1, 1'b0, IR | WR | BSY);
    foreach (tbl[i]) begin
      @(posedge clk);
      #1 drive(tbl[i].r, tbl[i].rn, tbl[i].o, tbl[i].rd);
      @(negedge clk);
      check($sformatf("vec%0d", i), outs, tbl[i].e);
    end
    #2 rst = 1'b1;
    #1 check("rst_mid_sta", outs, CLR | BSY);
    @(posedge clk);
    #1 drive(1'b0, 1'b1, 2'd0, 1'b1);
    @(negedge clk);
    check("rst_release_init", outs, CLR | BSY);
    @(posedge clk);
    @(negedge clk);
    check("rst_then_fetch", outs, F_RDY);
    err_cycles = 0;
    for (int i = 0; i < 600; i++) begin
      logic r, rn, rd;
      logic [1:0] o;
      @(posedge clk);
      r = i == 0 || err_cycles > 2 || $urandom_range(0, 199) == 0;
      rn = $urandom_range(0, 9) != 0;
      o = 2'($urandom_range(0, 3));
      rd = $urandom_range(0, 9) < 7;
      #1 drive(r, rn, o, rd);
      if (r) begin
        m_phase = P_INIT;
        m_waits = 0;
      end
      @(negedge clk);
      model(r, rn, o, rd, e);
      check($sformatf("rand%0d", i), outs, e);
      err_cycles = m_phase == P_ERR ? err_cycles + 1 : 0;
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
